voice_alloc: RTL

- Polyphonic voice scheduler between the MIDI parser and the oscillator/envelope voices.
- Consumes one-cycle note_on/note_off pulses with note_num/note_vel from the parser.
- Allocates and releases VOICES voice slots, steals the oldest voice when all slots are busy, and drives per-voice gate/trigger/note/velocity to the synthesis datapath.

---
 rtl/voice_alloc_pkg.sv | 37 +++
 rtl/voice_alloc_if.sv | 28 ++
 rtl/voice_slot.sv | 47 ++++
 rtl/voice_alloc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared definitions for the voice allocator: FSM states, event encoding, field widths.
// No logic, so no latency.
// No backpressure.
package voice_alloc_pkg;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef enum logic {
        EV_ON  = 1'b0,
        EV_OFF = 1'b1
    } ev_t;

    typedef struct packed {
        ev_t               typ;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  vel;
    } event_t;

    // A note-on and a note-off in the same cycle is a velocity-0 note-on, i.e. a release.
    function automatic event_t decode_event(input logic off,
                                            input logic [NOTE_W-1:0] num,
                                            input logic [VEL_W-1:0] vel);
        event_t ev;
        ev.typ  = off ? EV_OFF : EV_ON;
        ev.note = num;
        ev.vel  = vel;
        return ev;
    endfunction

endpackage

// File: rtl/voice_alloc_if.sv
// Parser-side event inputs and per-voice outputs of the voice allocator.
// Pure wiring, no latency.
// No backpressure: overflowing events are reported on evt_dropped.
interface voice_alloc_if #(parameter int VOICES = 4);
    import voice_alloc_pkg::*;

    logic                     note_on;
    logic                     note_off;
    logic [NOTE_W-1:0]        note_num;
    logic [VEL_W-1:0]         note_vel;
    logic [VOICES-1:0]        voice_gate;
    logic [VOICES-1:0]        voice_trig;
    logic [NOTE_W*VOICES-1:0] voice_note;
    logic [VEL_W*VOICES-1:0]  voice_vel;
    logic                     busy;
    logic                     evt_dropped;

    modport master (
        output note_on, note_off, note_num, note_vel,
        input  voice_gate, voice_trig, voice_note, voice_vel, busy, evt_dropped
    );

    modport slave (
        input  note_on, note_off, note_num, note_vel,
        output voice_gate, voice_trig, voice_note, voice_vel, busy, evt_dropped
    );

endinterface

// File: rtl/voice_slot.sv
// One voice slot: gate, note, velocity and saturating age of a single voice.
// Updates visible one cycle after the command; trig is a one-cycle pulse.
// No backpressure; load_on wins over release_en, which wins over age_inc.
module voice_slot
    import voice_alloc_pkg::*;
#(
    parameter int AGE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_on,
    input  logic              release_en,
    input  logic              age_inc,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [VEL_W-1:0]  vel_in,
    output logic              gate,
    output logic              trig,
    output logic [NOTE_W-1:0] note,
    output logic [VEL_W-1:0]  vel,
    output logic [AGE_W-1:0]  age
);

    // Slot state; a steal is just a load_on on a gated slot, so the gate never drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate <= 1'b0;
            trig <= 1'b0;
            note <= '0;
            vel  <= '0;
            age  <= '0;
        end else begin
            trig <= load_on;
            if (load_on) begin
                gate <= 1'b1;
                note <= note_in;
                vel  <= vel_in;
                age  <= '0;
            end else if (release_en) begin
                gate <= 1'b0;
                age  <= '0;
            end else if (age_inc && gate && (age != '1)) begin
                age <= age + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans slots for match/free/oldest, then commits one event.
// Event in IDLE at cycle 0 is visible on outputs at cycle VOICES+2.
// No backpressure: one pending entry; further events while busy are dropped (evt_dropped).
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int AGE_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    voice_alloc_if.slave  bus
);

    localparam int IDX_W = $clog2(VOICES);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    event_t             cur_q, pend_q, in_ev;
    logic               pend_vld_q, drop_q, in_vld;
    logic               take_in, take_pend, store_pend, clr_pend, drop;

    logic               match_vld_q, free_vld_q, old_vld_q;
    logic [IDX_W-1:0]   match_idx_q, free_idx_q, old_idx_q, tgt;
    logic [AGE_W-1:0]   old_age_q;
    logic [VOICES-1:0]  off_mask_q;

    logic [VOICES-1:0]  gate, trig, load_on, release_en, age_inc;
    logic [NOTE_W-1:0]  note_s [VOICES];
    logic [VEL_W-1:0]   vel_s  [VOICES];
    logic [AGE_W-1:0]   age_s  [VOICES];
    logic               hit;

    assign in_vld = bus.note_on | bus.note_off;
    assign in_ev  = decode_event(bus.note_off, bus.note_num, bus.note_vel);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and event routing between input, pending buffer and cur.
    always_comb begin
        state_d    = state_q;
        take_in    = 1'b0;
        take_pend  = 1'b0;
        store_pend = 1'b0;
        clr_pend   = 1'b0;
        drop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    state_d = SCAN;
                    take_in = 1'b1;
                end
            end
            SCAN: begin
                if (idx_q == IDX_W'(VOICES - 1)) state_d = COMMIT;
                if (in_vld) begin
                    if (pend_vld_q) drop = 1'b1;
                    else            store_pend = 1'b1;
                end
            end
            COMMIT: begin
                // Pending is older than anything arriving now, so it goes first;
                // its slot frees up in the same cycle for the newcomer.
                if (pend_vld_q) begin
                    state_d   = SCAN;
                    take_pend = 1'b1;
                    if (in_vld) store_pend = 1'b1;
                    else        clr_pend   = 1'b1;
                end else if (in_vld) begin
                    state_d = SCAN;
                    take_in = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Current event, pending buffer, scan index and the delayed drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            drop_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            drop_q <= drop;
            if (take_in)        cur_q <= in_ev;
            else if (take_pend) cur_q <= pend_q;
            if (store_pend) begin
                pend_q     <= in_ev;
                pend_vld_q <= 1'b1;
            end else if (clr_pend) begin
                pend_vld_q <= 1'b0;
            end
            if (state_q == SCAN) idx_q <= idx_q + IDX_W'(1);
            else                 idx_q <= '0;
        end
    end

    assign hit = gate[idx_q] && (note_s[idx_q] == cur_q.note);

    // Candidate registers: cleared when a new event enters the scan, updated one slot per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            off_mask_q  <= '0;
        end else if (take_in || take_pend) begin
            match_vld_q <= 1'b0;
            free_vld_q  <= 1'b0;
            old_vld_q   <= 1'b0;
            off_mask_q  <= '0;
        end else if (state_q == SCAN) begin
            if (hit && !match_vld_q) begin
                match_vld_q <= 1'b1;
                match_idx_q <= idx_q;
            end
            if (!gate[idx_q] && !free_vld_q) begin
                free_vld_q <= 1'b1;
                free_idx_q <= idx_q;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (gate[idx_q] && (!old_vld_q || (age_s[idx_q] > old_age_q))) begin
                old_vld_q <= 1'b1;
                old_idx_q <= idx_q;
                old_age_q <= age_s[idx_q];
            end
            if (hit) off_mask_q[idx_q] <= 1'b1;
        end
    end

    // Commit decode: match, else free, else oldest for note-on; masked release for note-off.
    always_comb begin
        tgt        = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : old_idx_q);
        load_on    = '0;
        release_en = '0;
        age_inc    = '0;
        if (state_q == COMMIT) begin
            for (int i = 0; i < VOICES; i++) begin
                if (cur_q.typ == EV_ON) begin
                    load_on[i] = (tgt == IDX_W'(i));
                    age_inc[i] = 1'b1;
                end else begin
                    release_en[i] = off_mask_q[i];
                end
            end
        end
    end

    for (genvar i = 0; i < VOICES; i++) begin : g_slot
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load_on    (load_on[i]),
            .release_en (release_en[i]),
            .age_inc    (age_inc[i]),
            .note_in    (cur_q.note),
            .vel_in     (cur_q.vel),
            .gate       (gate[i]),
            .trig       (trig[i]),
            .note       (note_s[i]),
            .vel        (vel_s[i]),
            .age        (age_s[i])
        );
        assign bus.voice_note[NOTE_W*i +: NOTE_W] = note_s[i];
        assign bus.voice_vel[VEL_W*i +: VEL_W]    = vel_s[i];
    end

    assign bus.voice_gate  = gate;
    assign bus.voice_trig  = trig;
    assign bus.busy        = (state_q != IDLE);
    assign bus.evt_dropped = drop_q;

endmodule
